// File: rtl/nic_dma_wb_slave.sv
// Pipelined Wishbone B4 slave for the NIC DMA buffer RAM, sharing a single-port RAM with a priority core port.
// Optional feature: define NIC_DMA_WB_ERR_EN to answer out-of-range addresses with dma_err_o.

module nic_dma_wb_slave #(
   parameter int g_ADDR_BITS  = 10,
   parameter int g_FIFO_DEPTH = 4
) (
   input  logic                   clk_sys_i,
   input  logic                   rst_n_i,
   input  logic                   dma_cyc_i,
   input  logic                   dma_stb_i,
   input  logic                   dma_we_i,
   input  logic [3:0]             dma_sel_i,
   input  logic [31:0]            dma_adr_i,
   input  logic [31:0]            dma_dat_i,
   output logic [31:0]            dma_dat_o,
   output logic                   dma_ack_o,
   output logic                   dma_err_o,
   output logic                   dma_stall_o,
   input  logic                   core_req_i,
   input  logic                   core_we_i,
   input  logic [g_ADDR_BITS-1:0] core_adr_i,
   input  logic [31:0]            core_dat_i,
   output logic [31:0]            core_dat_o,
   output logic                   core_ack_o
);

   localparam int PTR_W = (g_FIFO_DEPTH > 1) ? $clog2(g_FIFO_DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam int WORDS = 1 << g_ADDR_BITS;

   typedef struct packed {
      logic                   we;
      logic [3:0]             sel;
      logic [g_ADDR_BITS-1:0] adr;
      logic [31:0]            dat;
      logic                   oor;
   } cmd_t;

   cmd_t                   fifo_q [g_FIFO_DEPTH];
   logic [31:0]            mem [WORDS];
   logic [31:0]            ram_rdata_q;

   logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]       count_q, count_d;
   logic                   s1_vld_q, s1_err_q, s1_rd_q;
   logic                   ack_q, err_q;
   logic [31:0]            dat_q;
   logic                   core_ack_q;
   logic [31:0]            core_hold_q;

   cmd_t                   push_cmd, head_cmd;
   logic                   in_oor, push, pop, bus_ram;
   logic                   ram_en;
   logic [g_ADDR_BITS-1:0] ram_adr;
   logic [31:0]            ram_wdata;
   logic [3:0]             ram_be;
   logic                   unused_adr;

`ifdef NIC_DMA_WB_ERR_EN
   assign in_oor     = |dma_adr_i[31:g_ADDR_BITS+2];
   assign unused_adr = ^dma_adr_i[1:0];
`else
   assign in_oor     = 1'b0;
   assign unused_adr = ^{dma_adr_i[31:g_ADDR_BITS+2], dma_adr_i[1:0]};
`endif

   assign push_cmd = '{we: dma_we_i, sel: dma_sel_i, adr: dma_adr_i[g_ADDR_BITS+1:2],
                       dat: dma_dat_i, oor: in_oor};
   assign head_cmd = fifo_q[rd_ptr_q];

   assign dma_stall_o = (count_q == CNT_W'(g_FIFO_DEPTH));
   assign push        = dma_cyc_i & dma_stb_i & ~dma_stall_o;
   // Out-of-range entries never touch the RAM, so they may leave even while the core owns it.
   assign pop         = dma_cyc_i & (count_q != '0) & (~core_req_i | head_cmd.oor);
   assign bus_ram     = pop & ~head_cmd.oor;

   assign ram_en    = core_req_i | bus_ram;
   assign ram_adr   = core_req_i ? core_adr_i : head_cmd.adr;
   assign ram_wdata = core_req_i ? core_dat_i : head_cmd.dat;
   assign ram_be    = core_req_i ? {4{core_we_i}}
                                 : ((bus_ram & head_cmd.we) ? head_cmd.sel : 4'b0000);

   // NOTE: combinational next-state uses blocking assignments, each output defaulted first so no latch is inferred.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (!dma_cyc_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
         if (push && !pop)      count_d = count_q + CNT_W'(1);
         else if (!push && pop) count_d = count_q - CNT_W'(1);
      end
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // NOTE: storage arrays carry no reset; pointers and valid flags alone define their contents.
   always_ff @(posedge clk_sys_i) begin
      if (push) fifo_q[wr_ptr_q] <= push_cmd;
   end

   // Single-port RAM, read-first, registered output shared by both ports.
   always_ff @(posedge clk_sys_i) begin
      if (ram_en) begin
         ram_rdata_q <= mem[ram_adr];
         for (int b = 0; b < 4; b++) begin
            if (ram_be[b]) mem[ram_adr][8*b +: 8] <= ram_wdata[8*b +: 8];
         end
      end
   end

   // Response pipeline: issue stage, then registered bus response; a dropped cycle kills both.
   always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         s1_vld_q <= 1'b0;
         s1_err_q <= 1'b0;
         s1_rd_q  <= 1'b0;
         ack_q    <= 1'b0;
         err_q    <= 1'b0;
         dat_q    <= '0;
      end else begin
         s1_vld_q <= pop;
         s1_err_q <= head_cmd.oor;
         s1_rd_q  <= ~head_cmd.we;
         ack_q    <= dma_cyc_i & s1_vld_q & ~s1_err_q;
         err_q    <= dma_cyc_i & s1_vld_q & s1_err_q;
         if (dma_cyc_i && s1_vld_q) begin
            if (s1_err_q)     dat_q <= '0;
            else if (s1_rd_q) dat_q <= ram_rdata_q;
         end
      end
   end

   always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         core_ack_q  <= 1'b0;
         core_hold_q <= '0;
      end else begin
         core_ack_q <= core_req_i;
         if (core_ack_q) core_hold_q <= ram_rdata_q;
      end
   end

   assign dma_ack_o  = ack_q & dma_cyc_i;
`ifdef NIC_DMA_WB_ERR_EN
   assign dma_err_o  = err_q & dma_cyc_i;
`else
   assign dma_err_o  = 1'b0;
`endif
   assign dma_dat_o  = dat_q;
   assign core_ack_o = core_ack_q;
   assign core_dat_o = core_ack_q ? ram_rdata_q : core_hold_q;

endmodule

// File: tb/tb_nic_dma_wb_slave.sv
// Self-checking bench for nic_dma_wb_slave: queue-based reference model, per-cycle compare, directed and random stimulus.
// Build with NIC_DMA_WB_ERR_EN defined to also exercise the out-of-range error response.

module tb_nic_dma_wb_slave;

   localparam int AB    = 10;
   localparam int DEPTH = 4;
   localparam int WORDS = 1 << AB;
   localparam int NW    = 32;

   logic          clk_sys_i = 1'b0;
   logic          rst_n_i   = 1'b0;
   logic          dma_cyc_i, dma_stb_i, dma_we_i;
   logic [3:0]    dma_sel_i;
   logic [31:0]   dma_adr_i, dma_dat_i, dma_dat_o;
   logic          dma_ack_o, dma_err_o, dma_stall_o;
   logic          core_req_i, core_we_i;
   logic [AB-1:0] core_adr_i;
   logic [31:0]   core_dat_i, core_dat_o;
   logic          core_ack_o;

   always #5 clk_sys_i = ~clk_sys_i;

   nic_dma_wb_slave #(.g_ADDR_BITS(AB), .g_FIFO_DEPTH(DEPTH)) dut (
      .clk_sys_i  (clk_sys_i),
      .rst_n_i    (rst_n_i),
      .dma_cyc_i  (dma_cyc_i),
      .dma_stb_i  (dma_stb_i),
      .dma_we_i   (dma_we_i),
      .dma_sel_i  (dma_sel_i),
      .dma_adr_i  (dma_adr_i),
      .dma_dat_i  (dma_dat_i),
      .dma_dat_o  (dma_dat_o),
      .dma_ack_o  (dma_ack_o),
      .dma_err_o  (dma_err_o),
      .dma_stall_o(dma_stall_o),
      .core_req_i (core_req_i),
      .core_we_i  (core_we_i),
      .core_adr_i (core_adr_i),
      .core_dat_i (core_dat_i),
      .core_dat_o (core_dat_o),
      .core_ack_o (core_ack_o)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic bit is_oor(input logic [31:0] a);
`ifdef NIC_DMA_WB_ERR_EN
      return a[31:AB+2] != '0;
`else
      return 1'b0;
`endif
   endfunction

   // Reference model: pending requests in a queue, issued responses tagged with their due edge.
   typedef struct { bit we; bit [3:0] sel; int widx; bit [31:0] dat; bit oor; } req_t;
   typedef struct { int due; bit err; bit rd; bit [31:0] dat; } rsp_t;

   req_t      mq[$];
   rsp_t      ms[$];
   bit [31:0] mmem [WORDS];
   bit        mknown [WORDS];
   int        m_edge = 0;
   bit        cur_v, cur_err, cur_rd;
   bit [31:0] cur_dat;
   bit        exp_core_ack, exp_core_known, exp_stall;
   bit [31:0] exp_core_dat;

   always @(posedge clk_sys_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         mq.delete();
         ms.delete();
         cur_v          = 1'b0;
         exp_core_ack   = 1'b0;
         exp_core_known = 1'b0;
         exp_core_dat   = '0;
         exp_stall      = 1'b0;
      end else begin
         bit   stall_before;
         req_t h;
         rsp_t r;
         int   cw;
         m_edge++;
         stall_before = (mq.size() == DEPTH);
         cw           = int'(core_adr_i);
         exp_core_ack = core_req_i;
         if (core_req_i) begin
            exp_core_dat   = mmem[cw];
            exp_core_known = mknown[cw];
            if (core_we_i) begin
               mmem[cw]   = core_dat_i;
               mknown[cw] = 1'b1;
            end
         end
         cur_v = 1'b0;
         if (!dma_cyc_i) begin
            mq.delete();
            ms.delete();
         end else begin
            if (ms.size() > 0 && ms[0].due == m_edge) begin
               r       = ms.pop_front();
               cur_v   = 1'b1;
               cur_err = r.err;
               cur_rd  = r.rd;
               cur_dat = r.dat;
            end
            if (mq.size() > 0 && (!core_req_i || mq[0].oor)) begin
               h     = mq.pop_front();
               r.due = m_edge + 1;
               r.err = h.oor;
               r.rd  = !h.we;
               r.dat = '0;
               if (!h.oor) begin
                  if (h.we) begin
                     for (int b = 0; b < 4; b++)
                        if (h.sel[b]) mmem[h.widx][8*b +: 8] = h.dat[8*b +: 8];
                  end else begin
                     r.dat = mmem[h.widx];
                  end
               end
               ms.push_back(r);
            end
            if (dma_stb_i && !stall_before) begin
               h.we   = dma_we_i;
               h.sel  = dma_sel_i;
               h.widx = int'(dma_adr_i[AB+1:2]);
               h.dat  = dma_dat_i;
               h.oor  = is_oor(dma_adr_i);
               mq.push_back(h);
            end
         end
         exp_stall = (mq.size() == DEPTH);
      end
   end

   // Edge counter and monitor state for the directed, hand-computed expectations.
   typedef struct { int cyc; bit err; logic [31:0] dat; } obs_t;
   obs_t obs[$];
   int   ecnt = 0;
   bit   chk_en = 1'b0;
   bit   stall_seen;
   int   core_cnt, core_first, core_last, core5_bad;

   always @(posedge clk_sys_i) ecnt <= ecnt + 1;

   always @(negedge clk_sys_i) begin
      bit ea, ee;
      ea = cur_v && !cur_err && dma_cyc_i;
      ee = cur_v && cur_err && dma_cyc_i;
      if (chk_en) begin
         check("ack", dma_ack_o, ea);
         check("err", dma_err_o, ee);
         check("stall", dma_stall_o, exp_stall);
         check("core_ack", core_ack_o, exp_core_ack);
         if (ea && cur_rd) check("rdata", dma_dat_o, cur_dat);
         if (ee)           check("err_dat", dma_dat_o, 32'h0);
         if (exp_core_ack && exp_core_known) check("core_dat", core_dat_o, exp_core_dat);
      end
      if (dma_ack_o || dma_err_o) obs.push_back('{ecnt, dma_err_o, dma_dat_o});
      if (dma_stall_o) stall_seen = 1'b1;
      if (core_ack_o) begin
         if (core_cnt == 0) core_first = ecnt;
         core_last = ecnt;
         core_cnt++;
         if (core_dat_o !== 32'hA500_0005) core5_bad++;
      end
   end

   task automatic clr_mon();
      obs.delete();
      stall_seen = 1'b0;
      core_cnt   = 0;
      core5_bad  = 0;
   endtask

   task automatic tick();
      @(posedge clk_sys_i);
      #1;
   endtask

   task automatic set_idle();
      dma_cyc_i  = 1'b1;
      dma_stb_i  = 1'b0;
      dma_we_i   = 1'b0;
      dma_sel_i  = 4'h0;
      dma_adr_i  = '0;
      dma_dat_i  = '0;
      core_req_i = 1'b0;
      core_we_i  = 1'b0;
      core_adr_i = '0;
      core_dat_i = '0;
   endtask

   task automatic set_bus(input bit we, input logic [3:0] sel, input logic [31:0] adr,
                          input logic [31:0] dat);
      dma_cyc_i = 1'b1;
      dma_stb_i = 1'b1;
      dma_we_i  = we;
      dma_sel_i = sel;
      dma_adr_i = adr;
      dma_dat_i = dat;
   endtask

   task automatic set_core(input bit req, input bit we, input logic [31:0] adr,
                           input logic [31:0] dat);
      core_req_i = req;
      core_we_i  = we;
      core_adr_i = adr[AB-1:0];
      core_dat_i = dat;
   endtask

   initial begin
      int a, acc, stall_after;
      bit stalled;

      set_idle();
      dma_cyc_i = 1'b0;
      rst_n_i   = 1'b0;
      repeat (3) tick();
      check("reset_stall", dma_stall_o, 1'b0);
      check("reset_ack", dma_ack_o, 1'b0);
      check("reset_dat", dma_dat_o, 32'h0);
      check("reset_core_dat", core_dat_o, 32'h0);
      rst_n_i = 1'b1;
      chk_en  = 1'b1;

      // Preload the words used below through the core port.
      for (int i = 0; i < NW; i++) begin
         set_core(1'b1, 1'b1, i, 32'hA500_0000 | i);
         tick();
      end
      set_idle();
      tick();

      // Back-to-back writes then reads, core idle.
      clr_mon();
      a = ecnt + 1;
      set_bus(1'b1, 4'hF, 32'h0, 32'hDEAD_BEEF); tick();
      set_bus(1'b1, 4'hF, 32'h4, 32'hCAFE_BABE); tick();
      set_bus(1'b0, 4'hF, 32'h0, 32'h0);         tick();
      set_bus(1'b0, 4'hF, 32'h4, 32'h0);         tick();
      set_idle();
      repeat (6) tick();
      check("t1_nresp", obs.size(), 4);
      if (obs.size() == 4) begin
         for (int i = 0; i < 4; i++) check("t1_lat", obs[i].cyc, a + 2 + i);
         check("t1_rd0", obs[2].dat, 32'hDEAD_BEEF);
         check("t1_rd1", obs[3].dat, 32'hCAFE_BABE);
      end
      check("t1_stall", stall_seen, 1'b0);

      // Byte-select merge.
      clr_mon();
      set_bus(1'b1, 4'hF, 32'h8, 32'hFFFF_FFFF); tick();
      set_bus(1'b1, 4'h5, 32'h8, 32'h1234_5678); tick();
      set_bus(1'b0, 4'hF, 32'h8, 32'h0);         tick();
      set_idle();
      repeat (6) tick();
      check("t2_nresp", obs.size(), 3);
      if (obs.size() == 3) check("t2_merge", obs[2].dat, 32'hFF34_FF78);

      // Core holds the RAM for 6 cycles while the bus streams 6 writes.
      clr_mon();
      a           = ecnt + 1;
      acc         = 0;
      stall_after = -1;
      for (int n = 0; n < 40 && acc < 6; n++) begin
         int edge_n;
         edge_n = ecnt + 1;
         set_bus(1'b1, 4'hF, (16 + acc) << 2, 32'h5A5A_0000 | acc);
         set_core((edge_n >= a + 1) && (edge_n <= a + 6), 1'b0, 5, 0);
         stalled = dma_stall_o;
         if (stalled && stall_after < 0) stall_after = acc;
         tick();
         if (!stalled) acc++;
      end
      set_idle();
      repeat (12) tick();
      check("t3_accepted", acc, 6);
      check("t3_stall_after", stall_after, 4);
      check("t3_nresp", obs.size(), 6);
      if (obs.size() == 6) begin
         check("t3_first_ack", obs[0].cyc, a + 8);
         check("t3_last_ack", obs[5].cyc, a + 13);
      end
      check("t3_core_cnt", core_cnt, 6);
      check("t3_core_first", core_first, a + 1);
      check("t3_core_span", core_last - core_first, 5);
      check("t3_core_dat", core5_bad, 0);

      // Three writes queued behind the core, then the cycle is aborted.
      clr_mon();
      for (int k = 0; k < 3; k++) begin
         set_bus(1'b1, 4'hF, (24 + k) << 2, 32'h1111_0000 | k);
         set_core(1'b1, 1'b0, 7, 0);
         tick();
      end
      dma_cyc_i = 1'b0;
      dma_stb_i = 1'b0;
      tick();
      set_idle();
      repeat (4) tick();
      check("t4_no_ack", obs.size(), 0);
      clr_mon();
      a = ecnt + 1;
      for (int k = 0; k < 3; k++) begin
         set_bus(1'b0, 4'hF, (24 + k) << 2, 32'h0);
         tick();
      end
      set_idle();
      repeat (6) tick();
      check("t4_nresp", obs.size(), 3);
      if (obs.size() == 3) begin
         check("t4_lat", obs[0].cyc, a + 2);
         for (int k = 0; k < 3; k++) check("t4_unchanged", obs[k].dat, 32'hA500_0018 + k);
      end

`ifdef NIC_DMA_WB_ERR_EN
      // Out-of-range read between two valid reads.
      clr_mon();
      set_bus(1'b0, 4'hF, 32'h0000_0000, 32'h0); tick();
      set_bus(1'b0, 4'hF, 32'h0000_1000, 32'h0); tick();
      set_bus(1'b0, 4'hF, 32'h0000_0004, 32'h0); tick();
      set_idle();
      repeat (6) tick();
      check("t5_nresp", obs.size(), 3);
      if (obs.size() == 3) begin
         check("t5_e0", obs[0].err, 1'b0);
         check("t5_d0", obs[0].dat, 32'hDEAD_BEEF);
         check("t5_e1", obs[1].err, 1'b1);
         check("t5_d1", obs[1].dat, 32'h0);
         check("t5_e2", obs[2].err, 1'b0);
         check("t5_d2", obs[2].dat, 32'hCAFE_BABE);
         check("t5_order", obs[2].cyc - obs[0].cyc, 2);
      end
`endif

      // Reset with two requests pending behind the core.
      clr_mon();
      set_core(1'b1, 1'b0, 5, 0);
      set_bus(1'b1, 4'hF, 28 << 2, 32'h7777_0000); tick();
      set_bus(1'b1, 4'hF, 29 << 2, 32'h7777_0001); tick();
      dma_stb_i = 1'b0;
      check("t6_core_ack_pre", core_ack_o, 1'b1);
      rst_n_i = 1'b0;
      #1;
      check("t6_rst_ack", dma_ack_o, 1'b0);
      check("t6_rst_stall", dma_stall_o, 1'b0);
      check("t6_rst_dat", dma_dat_o, 32'h0);
      check("t6_rst_core_ack", core_ack_o, 1'b0);
      check("t6_rst_core_dat", core_dat_o, 32'h0);
      set_idle();
      repeat (2) tick();
      rst_n_i = 1'b1;
      clr_mon();
      repeat (6) tick();
      check("t6_no_ack", obs.size(), 0);
      for (int k = 0; k < 2; k++) begin
         set_bus(1'b0, 4'hF, (28 + k) << 2, 32'h0);
         tick();
      end
      set_idle();
      repeat (6) tick();
      check("t6_nresp", obs.size(), 2);
      if (obs.size() == 2) begin
         check("t6_rd0", obs[0].dat, 32'hA500_001C);
         check("t6_rd1", obs[1].dat, 32'hA500_001D);
      end

      // Randomized traffic against the model.
      for (int n = 0; n < 800; n++) begin
         logic [31:0] upper, adr;
         upper = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 255) : 0;
         adr   = (upper << (AB + 2)) | ($urandom_range(0, NW - 1) << 2) | $urandom_range(0, 3);
         dma_cyc_i  = ($urandom_range(0, 19) != 0);
         dma_stb_i  = $urandom_range(0, 1);
         dma_we_i   = $urandom_range(0, 1);
         dma_sel_i  = 4'($urandom);
         dma_adr_i  = adr;
         dma_dat_i  = $urandom;
         core_req_i = ($urandom_range(0, 3) == 0);
         core_we_i  = $urandom_range(0, 1);
         core_adr_i = AB'($urandom_range(0, NW - 1));
         core_dat_i = $urandom;
         tick();
      end
      set_idle();
      repeat (8) tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
